// File: rtl/l2_arb_pkg.sv
// Shared types and constants for the L2 line-port arbiter.
package l2_arb_pkg;

  localparam int unsigned ADDR_W = 28;
  localparam int unsigned DATA_W = 128;
  localparam int unsigned CNT_W  = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_I  = 2'd1,
    BUSY_D  = 2'd2,
    RELEASE = 2'd3
  } state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  typedef struct packed {
    logic              read;
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } l2_req_t;

  // Saturating increment for the debug counters.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && (v != {CNT_W{1'b1}})) ? CNT_W'(v + CNT_W'(1)) : v;
  endfunction

endpackage

// File: rtl/l2_port_arbiter_if.sv
// L1 I/D request buses and the shared L2 line port, grouped for the arbiter.
interface l2_port_arbiter_if
  import l2_arb_pkg::*;
  ;

  logic              l1i_read;
  logic              l1i_write;
  logic [ADDR_W-1:0] l1i_addr;
  logic [DATA_W-1:0] l1i_wdata;
  logic [DATA_W-1:0] l1i_rdata;
  logic              l1i_ready;

  logic              l1d_read;
  logic              l1d_write;
  logic [ADDR_W-1:0] l1d_addr;
  logic [DATA_W-1:0] l1d_wdata;
  logic [DATA_W-1:0] l1d_rdata;
  logic              l1d_ready;

  logic              L2_read;
  logic              L2_write;
  logic [ADDR_W-1:0] L2_addr;
  logic [DATA_W-1:0] L2_wdata;
  logic [DATA_W-1:0] L2_rdata;
  logic              L2_ready;

  // Arbiter view.
  modport slave (
    input  l1i_read, l1i_write, l1i_addr, l1i_wdata,
    output l1i_rdata, l1i_ready,
    input  l1d_read, l1d_write, l1d_addr, l1d_wdata,
    output l1d_rdata, l1d_ready,
    output L2_read, L2_write, L2_addr, L2_wdata,
    input  L2_rdata, L2_ready
  );

  // Environment view: L1 requesters and the L2 controller.
  modport master (
    output l1i_read, l1i_write, l1i_addr, l1i_wdata,
    input  l1i_rdata, l1i_ready,
    output l1d_read, l1d_write, l1d_addr, l1d_wdata,
    input  l1d_rdata, l1d_ready,
    input  L2_read, L2_write, L2_addr, L2_wdata,
    output L2_rdata, L2_ready
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: on a tie, the side that did not win last time wins.
module rr_arb2
  import l2_arb_pkg::*;
(
  input  logic   req_i,
  input  logic   req_d,
  input  owner_e last_grant,
  output logic   gnt_i,
  output logic   gnt_d
);

  assign gnt_d = req_d & (~req_i | (last_grant == OWN_I));
  assign gnt_i = req_i & (~req_d | (last_grant == OWN_D));

endmodule

// File: rtl/l2_port_arbiter.sv
// Shares one L2 line port between the L1 I-cache and D-cache; one owner at a time,
// downstream request registered and held until L2_ready, then a one-cycle release gap.
module l2_port_arbiter
  import l2_arb_pkg::*;
(
  input  logic              clk,
  input  logic              proc_reset,
  l2_port_arbiter_if.slave  bus
);

  state_e            state_q, state_d;
  owner_e            last_q, last_d;
  l2_req_t           l2_q, l2_d;
  l2_req_t           cap_i, cap_d;
  logic [CNT_W-1:0]  grant_cnt_i_q, grant_cnt_d_q, wait_cnt_q;
  logic              req_i, req_d, gnt_i, gnt_d;
  logic              inc_i, inc_d, inc_wait;
  logic              l1i_ready_c, l1d_ready_c;
  logic [DATA_W-1:0] l1i_rdata_c, l1d_rdata_c;

  assign req_i = bus.l1i_read | bus.l1i_write;
  assign req_d = bus.l1d_read | bus.l1d_write;

  // A write wins over a simultaneous read on the same side.
  assign cap_i = '{read: bus.l1i_read & ~bus.l1i_write, write: bus.l1i_write,
                   addr: bus.l1i_addr, wdata: bus.l1i_wdata};
  assign cap_d = '{read: bus.l1d_read & ~bus.l1d_write, write: bus.l1d_write,
                   addr: bus.l1d_addr, wdata: bus.l1d_wdata};

  rr_arb2 u_rr_arb2 (
    .req_i      (req_i),
    .req_d      (req_d),
    .last_grant (last_q),
    .gnt_i      (gnt_i),
    .gnt_d      (gnt_d)
  );

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    l2_d        = l2_q;
    l1i_ready_c = 1'b0;
    l1d_ready_c = 1'b0;
    l1i_rdata_c = '0;
    l1d_rdata_c = '0;
    inc_i       = 1'b0;
    inc_d       = 1'b0;
    inc_wait    = 1'b0;
    case (state_q)
      IDLE: begin
        if (gnt_d) begin
          l2_d    = cap_d;
          last_d  = OWN_D;
          inc_d   = 1'b1;
          state_d = BUSY_D;
        end else if (gnt_i) begin
          l2_d    = cap_i;
          last_d  = OWN_I;
          inc_i   = 1'b1;
          state_d = BUSY_I;
        end
      end
      BUSY_I: begin
        inc_wait = req_d;
        if (bus.L2_ready) begin
          l1i_ready_c = 1'b1;
          l1i_rdata_c = bus.L2_rdata;
          l2_d.read   = 1'b0;
          l2_d.write  = 1'b0;
          state_d     = RELEASE;
        end
      end
      BUSY_D: begin
        inc_wait = req_i;
        if (bus.L2_ready) begin
          l1d_ready_c = 1'b1;
          l1d_rdata_c = bus.L2_rdata;
          l2_d.read   = 1'b0;
          l2_d.write  = 1'b0;
          state_d     = RELEASE;
        end
      end
      RELEASE: begin
        // Owner drops its request here; only the other side can be waiting.
        inc_wait = (last_q == OWN_I) ? req_d : req_i;
        state_d  = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      state_q       <= IDLE;
      last_q        <= OWN_I;
      l2_q          <= '0;
      grant_cnt_i_q <= '0;
      grant_cnt_d_q <= '0;
      wait_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      last_q        <= last_d;
      l2_q          <= l2_d;
      grant_cnt_i_q <= sat_inc(grant_cnt_i_q, inc_i);
      grant_cnt_d_q <= sat_inc(grant_cnt_d_q, inc_d);
      wait_cnt_q    <= sat_inc(wait_cnt_q, inc_wait);
    end
  end

  assign bus.L2_read   = l2_q.read;
  assign bus.L2_write  = l2_q.write;
  assign bus.L2_addr   = l2_q.addr;
  assign bus.L2_wdata  = l2_q.wdata;
  assign bus.l1i_ready = l1i_ready_c;
  assign bus.l1i_rdata = l1i_rdata_c;
  assign bus.l1d_ready = l1d_ready_c;
  assign bus.l1d_rdata = l1d_rdata_c;

endmodule
